inert_spi_seq: RTL and testbench

- SPI transaction sequencer for the inertial sensor path; sits between the inertial interface datapath and the 16-bit SPI master.
- After reset, waits for sensor power-on, then issues the three configuration writes that enable the sensor's data-ready interrupt, gyro rate and rounding.
- Each rising edge of INT starts a yaw-low read followed by a yaw-high read; the block then presents the assembled 16-bit yaw rate with a one-clock valid pulse.
- A per-transaction watchdog retries any SPI transaction that never completes.

---
 rtl/inert_spi_seq_if.sv | 10 +
 rtl/inert_spi_seq.sv | 156 +++++++++++++++
 tb/tb_inert_spi_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/inert_spi_seq_if.sv
// SPI master handshake between the inertial sequencer and the 16-bit SPI master.
interface inert_spi_seq_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;

  modport master (output wrt, cmd, input done, resp);
  modport slave  (input wrt, cmd, output done, resp);
endinterface

// File: rtl/inert_spi_seq.sv
// Inertial sensor SPI sequencer: power-on wait, three config writes, then an
// INT-triggered yaw-low/yaw-high read pair with a per-transaction watchdog.
module inert_spi_seq #(
  parameter logic [15:0] POR_CYCLES = 16'hFFFF,
  parameter logic [11:0] TMO_CYCLES = 12'd2048,
  parameter logic [15:0] CFG0       = 16'h0D02,
  parameter logic [15:0] CFG1       = 16'h1160,
  parameter logic [15:0] CFG2       = 16'h1440,
  parameter logic [15:0] RD_L       = 16'hA600,
  parameter logic [15:0] RD_H       = 16'hA700
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            INT,
  inert_spi_seq_if.master spi,
  output logic            init_done,
  output logic            vld,
  output logic [15:0]     yaw_rt,
  output logic            err
);

  typedef enum logic [2:0] {
    PWR, CFG_ISS, CFG_WT, IDLE, RDL_ISS, RDL_WT, RDH_ISS, RDH_WT
  } state_t;

  state_t      state;
  logic [15:0] por_cnt;
  logic [11:0] wd;
  logic [1:0]  idx;
  logic [7:0]  low;
  logic        s1, s2, s3, pend;
  logic        int_rise, issue_rdl, tmo;
  logic        unused_resp_hi;

  assign int_rise       = s2 & ~s3;
  assign issue_rdl      = (state == IDLE) && pend;
  // done has priority over the timeout wherever tmo is consulted
  assign tmo            = (wd == TMO_CYCLES - 12'd1);
  assign unused_resp_hi = ^spi.resp[15:8];

  function automatic logic [15:0] cfg_word(input logic [1:0] i);
    case (i)
      2'd0:    cfg_word = CFG0;
      2'd1:    cfg_word = CFG1;
      default: cfg_word = CFG2;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWR;
      por_cnt   <= '0;
      wd        <= '0;
      idx       <= '0;
      low       <= '0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      pend      <= 1'b0;
      spi.wrt   <= 1'b0;
      spi.cmd   <= '0;
      init_done <= 1'b0;
      vld       <= 1'b0;
      yaw_rt    <= '0;
      err       <= 1'b0;
    end else begin
      s1      <= INT;
      s2      <= s1;
      s3      <= s2;
      // a rise coincident with the RDL issue keeps pend set
      pend    <= (pend & ~issue_rdl) | int_rise;
      spi.wrt <= 1'b0;
      vld     <= 1'b0;
      case (state)
        PWR: begin
          if (por_cnt == POR_CYCLES - 16'd1) begin
            state   <= CFG_ISS;
            idx     <= 2'd0;
            spi.wrt <= 1'b1;
            spi.cmd <= CFG0;
            wd      <= '0;
          end else begin
            por_cnt <= por_cnt + 16'd1;
          end
        end
        CFG_ISS: state <= CFG_WT;
        CFG_WT: begin
          if (spi.done) begin
            if (idx == 2'd2) begin
              state     <= IDLE;
              init_done <= 1'b1;
            end else begin
              idx     <= idx + 2'd1;
              state   <= CFG_ISS;
              spi.wrt <= 1'b1;
              spi.cmd <= cfg_word(idx + 2'd1);
              wd      <= '0;
            end
          end else if (tmo) begin
            err     <= 1'b1;
            state   <= CFG_ISS;
            spi.wrt <= 1'b1;
            spi.cmd <= cfg_word(idx);
            wd      <= '0;
          end else begin
            wd <= wd + 12'd1;
          end
        end
        IDLE: begin
          if (pend) begin
            state   <= RDL_ISS;
            spi.wrt <= 1'b1;
            spi.cmd <= RD_L;
            wd      <= '0;
          end
        end
        RDL_ISS: state <= RDL_WT;
        RDL_WT: begin
          if (spi.done || tmo) begin
            if (spi.done) begin
              low   <= spi.resp[7:0];
              state <= RDH_ISS;
            end else begin
              err   <= 1'b1;
              state <= RDL_ISS;
            end
            spi.wrt <= 1'b1;
            spi.cmd <= spi.done ? RD_H : RD_L;
            wd      <= '0;
          end else begin
            wd <= wd + 12'd1;
          end
        end
        RDH_ISS: state <= RDH_WT;
        RDH_WT: begin
          if (spi.done) begin
            yaw_rt <= {spi.resp[7:0], low};
            vld    <= 1'b1;
            state  <= IDLE;
          end else if (tmo) begin
            // only the high byte is retried; low stays captured
            err     <= 1'b1;
            state   <= RDH_ISS;
            spi.wrt <= 1'b1;
            spi.cmd <= RD_H;
            wd      <= '0;
          end else begin
            wd <= wd + 12'd1;
          end
        end
        default: state <= PWR;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_spi_seq.sv
// Directed bench for inert_spi_seq: config sequence, reads, watchdog retry,
// INT edge collapsing and mid-transaction reset.
module tb_inert_spi_seq;
  logic        clk = 1'b0;
  logic        rst, INT;
  logic        init_done, vld, err;
  logic [15:0] yaw_rt;
  int          n_assert = 0;
  int          n_fail = 0;
  int          nwrt = 0, nrdl = 0, nvld = 0;
  int          base_rdl, base_vld, base_wrt;

  inert_spi_seq_if spi();

  inert_spi_seq #(.POR_CYCLES(16'd16), .TMO_CYCLES(12'd32)) dut (
    .clk(clk), .rst(rst), .INT(INT), .spi(spi),
    .init_done(init_done), .vld(vld), .yaw_rt(yaw_rt), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (spi.wrt === 1'b1) begin
      nwrt++;
      if (spi.cmd === 16'hA600) nrdl++;
    end
    if (vld === 1'b1) nvld++;
  end

  initial begin
    #2_000_000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_cmd(input logic [15:0] c, input string tag);
    int n = 0;
    while (spi.wrt !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    chk({tag, "_wrt"}, {15'd0, spi.wrt}, 16'd1);
    chk(tag, spi.cmd, c);
  endtask

  task automatic respond(input int dly, input logic [7:0] b);
    tick(dly);
    spi.done = 1'b1;
    spi.resp = {8'hAB, b};
    tick(1);
    spi.done = 1'b0;
  endtask

  task automatic rd_high(input logic [7:0] b, input logic [15:0] exp_yaw,
                         input logic [15:0] prev_yaw, input string tag);
    tick(5);
    chk({tag, "_vld_pre"}, {15'd0, vld}, 16'd0);
    chk({tag, "_yaw_pre"}, yaw_rt, prev_yaw);
    spi.done = 1'b1;
    spi.resp = {8'hAB, b};
    tick(1);
    spi.done = 1'b0;
    chk({tag, "_vld"}, {15'd0, vld}, 16'd1);
    chk({tag, "_yaw"}, yaw_rt, exp_yaw);
    tick(1);
    chk({tag, "_vld_post"}, {15'd0, vld}, 16'd0);
  endtask

  task automatic int_pulse();
    INT = 1'b1;
    tick(2);
    INT = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wrt"}, {15'd0, spi.wrt}, 16'd0);
    chk({tag, "_cmd"}, spi.cmd, 16'h0000);
    chk({tag, "_init_done"}, {15'd0, init_done}, 16'd0);
    chk({tag, "_vld"}, {15'd0, vld}, 16'd0);
    chk({tag, "_yaw"}, yaw_rt, 16'h0000);
    chk({tag, "_err"}, {15'd0, err}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; INT = 1'b0; spi.done = 1'b0; spi.resp = '0;
    tick(3);
    chk_reset("rst");

    // power-on wait: first wrt 16 clocks after release
    rst = 1'b0;
    tick(15);
    chk("por_wrt_early", {15'd0, spi.wrt}, 16'd0);
    tick(1);
    chk("por_wrt", {15'd0, spi.wrt}, 16'd1);
    chk("cfg0", spi.cmd, 16'h0D02);
    respond(5, 8'h00);
    INT = 1'b1;   // edge during config must wait for IDLE
    wait_cmd(16'h1160, "cfg1");
    respond(5, 8'h00);
    INT = 1'b0;
    wait_cmd(16'h1440, "cfg2");
    tick(5);
    chk("init_pre", {15'd0, init_done}, 16'd0);
    spi.done = 1'b1;
    tick(1);
    spi.done = 1'b0;
    chk("init_done", {15'd0, init_done}, 16'd1);

    wait_cmd(16'hA600, "a_rdl");
    respond(5, 8'h34);
    wait_cmd(16'hA700, "a_rdh");
    rd_high(8'h12, 16'h1234, 16'h0000, "a");
    tick(30);
    chk("a_nrdl", 16'(nrdl), 16'd1);
    chk("a_nvld", 16'(nvld), 16'd1);

    // watchdog: withhold done on the first A700
    int_pulse();
    wait_cmd(16'hA600, "b_rdl");
    respond(5, 8'h80);
    wait_cmd(16'hA700, "b_rdh");
    base_rdl = nrdl;
    tick(32);
    chk("b_err_early", {15'd0, err}, 16'd0);
    chk("b_wrt_early", {15'd0, spi.wrt}, 16'd0);
    tick(1);
    chk("b_err", {15'd0, err}, 16'd1);
    chk("b_retry_wrt", {15'd0, spi.wrt}, 16'd1);
    chk("b_retry_cmd", spi.cmd, 16'hA700);
    rd_high(8'hFF, 16'hFF80, 16'h1234, "b");
    tick(20);
    chk("b_no_rdl_retry", 16'(nrdl - base_rdl), 16'd0);
    chk("b_err_sticky", {15'd0, err}, 16'd1);

    // two edges during pair 1 -> pair 2; pair 2 gets one edge plus one
    // coincident with the next RDL issue -> pairs 3 and 4
    base_rdl = nrdl;
    base_vld = nvld;
    int_pulse();
    wait_cmd(16'hA600, "c1_rdl");
    respond(5, 8'h11);
    wait_cmd(16'hA700, "c1_rdh");
    int_pulse();
    tick(2);
    int_pulse();
    tick(2);
    rd_high(8'h22, 16'h2211, 16'hFF80, "c1");
    wait_cmd(16'hA600, "c2_rdl");
    respond(5, 8'h33);
    wait_cmd(16'hA700, "c2_rdh");
    int_pulse();
    tick(2);
    INT = 1'b1;
    tick(1);
    chk("c2_yaw_pre", yaw_rt, 16'h2211);
    spi.done = 1'b1;
    spi.resp = 16'hAB44;
    tick(1);
    spi.done = 1'b0;
    chk("c2_vld", {15'd0, vld}, 16'd1);
    chk("c2_yaw", yaw_rt, 16'h4433);
    wait_cmd(16'hA600, "c3_rdl");
    INT = 1'b0;
    respond(5, 8'h55);
    wait_cmd(16'hA700, "c3_rdh");
    rd_high(8'h66, 16'h6655, 16'h4433, "c3");
    wait_cmd(16'hA600, "c4_rdl");
    respond(5, 8'h77);
    wait_cmd(16'hA700, "c4_rdh");
    rd_high(8'h88, 16'h8877, 16'h6655, "c4");
    tick(40);
    chk("c_nrdl", 16'(nrdl - base_rdl), 16'd4);
    chk("c_nvld", 16'(nvld - base_vld), 16'd4);

    // reset during RDL_WT, then a stray done from the aborted read
    int_pulse();
    wait_cmd(16'hA600, "d_rdl");
    tick(2);
    rst = 1'b1;
    tick(1);
    chk_reset("d_rst");
    rst = 1'b0;
    spi.done = 1'b1;
    spi.resp = 16'hAB99;
    tick(1);
    spi.done = 1'b0;
    tick(14);
    chk("d_por_wrt_early", {15'd0, spi.wrt}, 16'd0);
    chk("d_yaw_stray", yaw_rt, 16'h0000);
    tick(1);
    chk("d_por_wrt", {15'd0, spi.wrt}, 16'd1);
    chk("d_cfg0", spi.cmd, 16'h0D02);
    respond(5, 8'h00);
    wait_cmd(16'h1160, "d_cfg1");
    respond(5, 8'h00);
    wait_cmd(16'h1440, "d_cfg2");
    respond(5, 8'h00);
    chk("d_init_done", {15'd0, init_done}, 16'd1);
    base_wrt = nwrt;
    tick(30);
    chk("d_no_read", 16'(nwrt - base_wrt), 16'd0);
    chk("d_err_clr", {15'd0, err}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
